// File: rtl/ks_sum_stage_if.sv
// Handshake and payload bundle for the Kogge-Stone final sum stage.
// The slave modport is the stage's view; master is the producer/consumer view.
interface ks_sum_stage_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic             cin_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic [CNT_W-1:0] result_count;

   modport slave (
      input  in_valid, p_in, g_in, cin_in, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero, result_count
   );

   modport master (
      output in_valid, p_in, g_in, cin_in, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero, result_count
   );
endinterface

// File: rtl/ks_sum_stage.sv
// Final Kogge-Stone stage: forms sum/cout/ovf/zero from propagates and resolved
// carries, and registers the result behind a 2-entry valid/ready skid buffer.
module ks_sum_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   ks_sum_stage_if.slave bus
);
   localparam int unsigned PW = WIDTH + 3;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    main_q, main_d;
   logic [PW-1:0]    skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_c;
   logic [PW-1:0]    payload;
   logic             accept;
   logic             pop;

   // Sum bit i uses the carry out of bit i-1; bit 0 uses the adder carry-in.
   assign sum_c   = bus.p_in ^ {bus.g_in[WIDTH-2:0], bus.cin_in};
   assign payload = {sum_c, bus.g_in[WIDTH-1], bus.g_in[WIDTH-1] ^ bus.g_in[WIDTH-2], ~|sum_c};

   // Handshake flags come straight from state, so no combinational ready path exists.
   assign bus.in_ready  = (state_q != StFull);
   assign bus.out_valid = (state_q != StEmpty);
   assign accept        = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   assign {bus.sum, bus.cout, bus.ovf, bus.zero} = main_q;
   assign bus.result_count = cnt_q;

   // Next-state and register-write selection for the skid buffer.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               main_d  = payload;
               state_d = StOne;
            end
         end
         StOne: begin
            if (accept && !pop) begin
               skid_d  = payload;
               state_d = StFull;
            end else if (accept && pop) begin
               main_d = payload;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (pop) begin
               main_d  = skid_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   // Popped-result counter, wraps naturally at 2^CNT_W.
   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State, payload and counter registers; reset discards any in-flight results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
